// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR program sequencer and datapath:
// opcode encoding, sequencer states, field widths and a decode helper.
package lfsr_pkg;

    localparam int OPC_W = 6;
    localparam int IMM_W = 8;

    typedef enum logic [OPC_W-1:0] {
        OP_CFG_TAP   = 6'h01,
        OP_INIT_L    = 6'h02,
        OP_RUN       = 6'h03,
        OP_STORE     = 6'h04,
        OP_LOAD      = 6'h05,
        OP_INIT_ADDR = 6'h06,
        OP_ADD_ADDR  = 6'h07,
        OP_SET_REP   = 6'h08,
        OP_HALT      = 6'h3F
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_e;

    // True for opcodes that are handed to the datapath as op strobes.
    function automatic logic is_fwd_op(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_CFG_TAP, OP_INIT_L, OP_RUN, OP_STORE,
            OP_LOAD, OP_INIT_ADDR, OP_ADD_ADDR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_prog_seq_if.sv
// Instruction-ROM fetch bus plus the op strobe bus towards the LFSR datapath.
interface lfsr_prog_seq_if #(
    parameter int AW = 8,
    parameter int IW = 14
);
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          op_valid;
    logic [5:0]    op_code;
    logic [7:0]    op_imm;

    // Sequencer side: drives the ROM address and the op strobes.
    modport master (
        output pc,
        output op_valid,
        output op_code,
        output op_imm,
        input  instr
    );

    // ROM / datapath side.
    modport slave (
        input  pc,
        input  op_valid,
        input  op_code,
        input  op_imm,
        output instr
    );
endinterface

// File: rtl/lfsr_rep_cnt.sv
// Repeat down-counter for the run instruction: loaded with the repeat
// count before a run, decremented once per strobe, flags the final strobe.
module lfsr_rep_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       last
);
    logic [7:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 8'd0)) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign last = (count_reg == 8'd1);
endmodule

// File: rtl/lfsr_prog_seq.sv
// Program sequencer: fetches 14-bit words from the instruction ROM,
// forwards datapath ops as one-cycle strobes, expands run into rep
// strobes, and stops on halt or an illegal opcode.
module lfsr_prog_seq
    import lfsr_pkg::*;
#(
    parameter int            AW         = 8,
    parameter int            IW         = 14,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    lfsr_prog_seq_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_EXEC  = EXEC;
    localparam logic [1:0] S_HALT  = HALT;

    logic [1:0]       state_reg;
    logic [AW-1:0]    pc_reg;
    logic [IW-1:0]    ir_reg;
    logic [7:0]       rep_reg;
    logic             op_valid_reg;
    logic [OPC_W-1:0] op_code_reg;
    logic [IMM_W-1:0] op_imm_reg;
    logic             err_reg;

    logic [OPC_W-1:0] ir_opc;
    logic [IMM_W-1:0] ir_imm;
    logic [OPC_W-1:0] fetch_opc;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;

    assign ir_opc    = ir_reg[IW-1:IMM_W];
    assign ir_imm    = ir_reg[IMM_W-1:0];
    assign fetch_opc = bus.instr[IW-1:IMM_W];

    // The counter is reloaded on every fetch so a run always starts from rep.
    assign cnt_load = (state_reg == S_FETCH);
    assign cnt_dec  = (state_reg == S_EXEC) && (ir_opc == OP_RUN);

    lfsr_rep_cnt u_rep_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (rep_reg),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // Fetch/execute FSM. The strobe register is set while fetching so that
    // it is high exactly during the EXEC cycles of a forwarded op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pc_reg       <= START_ADDR;
            ir_reg       <= '0;
            rep_reg      <= 8'd1;
            op_valid_reg <= 1'b0;
            op_code_reg  <= '0;
            op_imm_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        pc_reg    <= START_ADDR;
                        err_reg   <= 1'b0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_reg    <= bus.instr;
                    state_reg <= S_EXEC;
                    if (is_fwd_op(fetch_opc)) begin
                        op_valid_reg <= 1'b1;
                        op_code_reg  <= fetch_opc;
                        op_imm_reg   <= bus.instr[IMM_W-1:0];
                    end
                end
                S_EXEC: begin
                    if (ir_opc == OP_RUN) begin
                        if (cnt_last) begin
                            op_valid_reg <= 1'b0;
                            pc_reg       <= pc_reg + AW'(1);
                            rep_reg      <= 8'd1;
                            state_reg    <= S_FETCH;
                        end else begin
                            op_valid_reg <= 1'b1;
                        end
                    end else if (is_fwd_op(ir_opc)) begin
                        op_valid_reg <= 1'b0;
                        pc_reg       <= pc_reg + AW'(1);
                        state_reg    <= S_FETCH;
                    end else if (ir_opc == OP_SET_REP) begin
                        // A zero repeat count would mean "no strobes"; treat it as one.
                        rep_reg   <= (ir_imm == 8'd0) ? 8'd1 : ir_imm;
                        pc_reg    <= pc_reg + AW'(1);
                        state_reg <= S_FETCH;
                    end else if (ir_opc == OP_HALT) begin
                        state_reg <= S_HALT;
                    end else begin
                        err_reg   <= 1'b1;
                        state_reg <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_reg    <= START_ADDR;
                        err_reg   <= 1'b0;
                        rep_reg   <= 8'd1;
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.op_valid = op_valid_reg;
    assign bus.op_code  = op_code_reg;
    assign bus.op_imm   = op_imm_reg;
    assign busy         = (state_reg == S_FETCH) || (state_reg == S_EXEC);
    assign done         = (state_reg == S_HALT);
    assign err          = err_reg;
endmodule

// File: tb/tb_lfsr_prog_seq.sv
// Directed bench for the LFSR program sequencer with a behavioural ROM.
module tb_lfsr_prog_seq;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] rom [256];

    lfsr_prog_seq_if bus ();
    assign bus.instr = rom[bus.pc];

    lfsr_prog_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe, n_run, streak, max_streak;
    bit seen_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic clear_stats();
        n_strobe   = 0;
        n_run      = 0;
        streak     = 0;
        max_streak = 0;
        seen_done  = 1'b0;
    endtask

    // Advance one cycle and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.op_valid) begin
            n_strobe++;
            if (bus.op_code == 6'h03) begin
                n_run++;
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
        end else begin
            streak = 0;
        end
        if (done) seen_done = 1'b1;
    endtask

    task automatic fill_rom(input logic [13:0] word);
        for (int i = 0; i < 256; i++) rom[i] = word;
    endtask

    // Pulse start and run until HALT or the cycle budget runs out.
    task automatic run_prog(input string tag, input int budget);
        int k;
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    initial begin
        int k;
        int prev_pc;
        bit wrapped;

        fill_rom(14'h3F00);
        clear_stats();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", bus.pc, 0);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_op_code", bus.op_code, 0);
        check("rst_op_imm", bus.op_imm, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A: cfg_tap 0x25 then halt, cycle by cycle
        rom[0] = 14'h0125;
        rom[1] = 14'h3F00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_fetch_busy", busy, 1);
        check("a_fetch_valid", bus.op_valid, 0);
        tick();
        check("a_strobe_valid", bus.op_valid, 1);
        check("a_strobe_code", bus.op_code, 6'h01);
        check("a_strobe_imm", bus.op_imm, 8'h25);
        tick();
        check("a_after_valid", bus.op_valid, 0);
        check("a_hold_code", bus.op_code, 6'h01);
        check("a_hold_imm", bus.op_imm, 8'h25);
        tick();
        check("a_exec_halt_done", done, 0);
        tick();
        check("a_done", done, 1);
        check("a_busy", busy, 0);
        check("a_pc", bus.pc, 1);
        check("a_err", err, 0);

        // B: set_rep 1, set_rep 4 (last wins), run, halt
        fill_rom(14'h3F00);
        rom[0] = 14'h0801;
        rom[1] = 14'h0804;
        rom[2] = 14'h0300;
        run_prog("b", 50);
        check("b_run_strobes", n_run, 4);
        check("b_all_strobes", n_strobe, 4);
        check("b_consecutive", max_streak, 4);
        check("b_pc", bus.pc, 3);
        check("b_err", err, 0);

        // C: rep returns to 1 after a run
        fill_rom(14'h3F00);
        rom[0] = 14'h0803;
        rom[1] = 14'h0300;
        rom[2] = 14'h0300;
        run_prog("c", 50);
        check("c_run_strobes", n_run, 4);
        check("c_longest_run", max_streak, 3);

        // C2: rep survives an intervening non-run op
        fill_rom(14'h3F00);
        rom[0] = 14'h0803;
        rom[1] = 14'h0200;
        rom[2] = 14'h0300;
        run_prog("c2", 50);
        check("c2_run_strobes", n_run, 3);
        check("c2_all_strobes", n_strobe, 4);

        // D: set_rep 0 behaves as 1
        fill_rom(14'h3F00);
        rom[0] = 14'h0800;
        rom[1] = 14'h0300;
        run_prog("d", 50);
        check("d_run_strobes", n_run, 1);

        // E: illegal opcode 0x2A at address 2
        fill_rom(14'h3F00);
        rom[0] = 14'h0125;
        rom[1] = 14'h0200;
        rom[2] = 14'h2A00;
        run_prog("e", 50);
        check("e_err", err, 1);
        check("e_pc", bus.pc, 2);
        check("e_strobes", n_strobe, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("e_restart_err", err, 0);
        check("e_restart_pc", bus.pc, 0);
        check("e_restart_busy", busy, 1);
        check("e_restart_done", done, 0);
        k = 0;
        while (!done && k < 50) begin
            tick();
            k++;
        end
        check("e_rehalt", done, 1);

        // F: no halt, 256 x init_L, pc wraps
        fill_rom(14'h0200);
        clear_stats();
        prev_pc = -1;
        wrapped = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 520; i++) begin
            tick();
            if (bus.op_valid) begin
                if (prev_pc == 255 && bus.pc == 8'd0) wrapped = 1'b1;
                prev_pc = int'(bus.pc);
            end
        end
        check("f_strobes", n_strobe, 260);
        check("f_wrapped", wrapped, 1);
        check("f_no_done", seen_done, 0);
        check("f_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // G: reset during the 3rd strobe of a 5-step run
        fill_rom(14'h3F00);
        rom[0] = 14'h0805;
        rom[1] = 14'h0300;
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (n_strobe < 3 && k < 20) begin
            tick();
            k++;
        end
        check("g_third_strobe", n_strobe, 3);
        rst_n = 1'b0;
        #1;
        check("g_rst_valid", bus.op_valid, 0);
        check("g_rst_busy", busy, 0);
        check("g_rst_code", bus.op_code, 0);
        check("g_rst_imm", bus.op_imm, 0);
        check("g_rst_pc", bus.pc, 0);
        check("g_rst_done", done, 0);
        #2;
        rst_n = 1'b1;
        clear_stats();
        repeat (10) tick();
        check("g_idle_strobes", n_strobe, 0);
        check("g_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
